// File: rtl/lvds_tx_serializer.sv
// N-lane LVDS transmit serialiser in the bit-clock domain: 1-deep pixel holding
// register, MSB-first lane shifters, forwarded clock-lane pattern and sticky underflow.
module lvds_tx_serializer #(
   parameter int                     LANES       = 4,
   parameter int                     RATIO       = 7,
   parameter logic [RATIO-1:0]       CLK_PATTERN = 7'b1100011,
   parameter logic [LANES*RATIO-1:0] IDLE_WORD   = {(LANES*RATIO){1'b0}}
) (
   input  logic                     lvdsBitClock,
   input  logic                     resetN,
   input  logic                     enable,
   input  logic [LANES*RATIO-1:0]   pixelData,
   input  logic                     pixelValid,
   output logic                     pixelReady,
   output logic [LANES-1:0]         lvdsData,
   output logic                     lvdsClkOut,
   output logic                     slotStart,
   output logic                     running,
   output logic                     underflow,
   input  logic                     underflowClear
);

   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   typedef enum logic [0:0] {ST_STOP = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                      state_r;
   state_t                      state_s;
   logic [CW-1:0]               cnt_r;
   logic                        hold_full_r;
   logic [LANES*RATIO-1:0]      hold_data_r;
   logic [LANES-1:0][RATIO-1:0] shreg_r;
   logic [RATIO-1:0]            clk_shreg_r;
   logic                        slot_start_r;
   logic                        underflow_r;

   logic running_s, last_s, start_s, load_s, stop_s, ready_s, xfer_s, starve_s;

   // Slot-boundary and handshake decode
   always_comb begin
      running_s = (state_r == ST_RUN);
      last_s    = running_s && (cnt_r == CNT_LAST);
      start_s   = !running_s && enable;
      // enable is only looked at on a slot boundary: high reloads, low stops
      load_s    = start_s || (last_s && enable);
      stop_s    = last_s && !enable;
      ready_s   = (enable || running_s) && !hold_full_r;
      xfer_s    = pixelValid && ready_s;
      // start edges load idle silently; only a running boundary counts as starved
      starve_s  = last_s && enable && !hold_full_r;
   end

   // Run/stop next-state
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_STOP: begin
            if (enable) state_s = ST_RUN;
            else        state_s = ST_STOP;
         end
         ST_RUN: begin
            if (stop_s) state_s = ST_STOP;
            else        state_s = ST_RUN;
         end
         default: state_s = ST_STOP;
      endcase
   end

   // State, slot counter and holding register
   always_ff @(posedge lvdsBitClock) begin
      if (!resetN) begin
         state_r     <= ST_STOP;
         cnt_r       <= {CW{1'b0}};
         hold_full_r <= 1'b0;
         hold_data_r <= {(LANES*RATIO){1'b0}};
      end else begin
         state_r <= state_s;
         if (load_s || stop_s) begin
            cnt_r <= {CW{1'b0}};
         end else if (running_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
         if (xfer_s) begin
            hold_data_r <= pixelData;
            hold_full_r <= 1'b1;
         end else if (load_s && hold_full_r) begin
            hold_full_r <= 1'b0;
         end else begin
            hold_full_r <= hold_full_r;
         end
      end
   end

   // Lane and clock-lane shifters plus slot marker
   always_ff @(posedge lvdsBitClock) begin
      if (!resetN) begin
         shreg_r      <= {(LANES*RATIO){1'b0}};
         clk_shreg_r  <= {RATIO{1'b0}};
         slot_start_r <= 1'b0;
      end else if (load_s) begin
         shreg_r      <= hold_full_r ? hold_data_r : IDLE_WORD;
         clk_shreg_r  <= CLK_PATTERN;
         slot_start_r <= 1'b1;
      end else if (stop_s) begin
         shreg_r      <= {(LANES*RATIO){1'b0}};
         clk_shreg_r  <= {RATIO{1'b0}};
         slot_start_r <= 1'b0;
      end else if (running_s) begin
         for (int l = 0; l < LANES; l++) begin
            shreg_r[l] <= {shreg_r[l][RATIO-2:0], 1'b0};
         end
         clk_shreg_r  <= {clk_shreg_r[RATIO-2:0], 1'b0};
         slot_start_r <= 1'b0;
      end else begin
         slot_start_r <= 1'b0;
      end
   end

   // Sticky underflow; a starved boundary beats a simultaneous clear
   always_ff @(posedge lvdsBitClock) begin
      if (!resetN) begin
         underflow_r <= 1'b0;
      end else if (starve_s) begin
         underflow_r <= 1'b1;
      end else if (underflowClear) begin
         underflow_r <= 1'b0;
      end else begin
         underflow_r <= underflow_r;
      end
   end

   // Lane outputs are the shifter MSBs
   always_comb begin
      lvdsData = {LANES{1'b0}};
      for (int l = 0; l < LANES; l++) begin
         lvdsData[l] = shreg_r[l][RATIO-1];
      end
   end

   assign lvdsClkOut = clk_shreg_r[RATIO-1];
   assign slotStart  = slot_start_r;
   assign running    = running_s;
   assign underflow  = underflow_r;
   assign pixelReady = ready_s;

endmodule

// File: tb/tb_lvds_tx_serializer.sv
// Scoreboard bench for lvds_tx_serializer: stimulus queues expected slot words,
// per-DUT monitors rebuild each slot from the serial lanes and compare.
module tb_lvds_tx_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetN, enable, pixelValid, underflowClear;
   logic [27:0] pixelData;
   logic        pixelReady, lvdsClkOut, slotStart, running, underflow;
   logic [3:0]  lvdsData;

   logic        resetN2, enable2, pixelValid2, underflowClear2;
   logic [4:0]  pixelData2;
   logic        pixelReady2, lvdsClkOut2, slotStart2, running2, underflow2;
   logic [0:0]  lvdsData2;

   int vectors = 0;
   int miscompares = 0;
   logic [27:0] sb_q[$];
   logic [4:0]  sb2_q[$];
   bit mon_busy = 1'b0;
   bit mon2_busy = 1'b0;

   lvds_tx_serializer dut (
      .lvdsBitClock(clk), .resetN(resetN), .enable(enable),
      .pixelData(pixelData), .pixelValid(pixelValid), .pixelReady(pixelReady),
      .lvdsData(lvdsData), .lvdsClkOut(lvdsClkOut), .slotStart(slotStart),
      .running(running), .underflow(underflow), .underflowClear(underflowClear)
   );

   lvds_tx_serializer #(.LANES(1), .RATIO(5), .CLK_PATTERN(5'b11100), .IDLE_WORD(5'b00000)) dut2 (
      .lvdsBitClock(clk), .resetN(resetN2), .enable(enable2),
      .pixelData(pixelData2), .pixelValid(pixelValid2), .pixelReady(pixelReady2),
      .lvdsData(lvdsData2), .lvdsClkOut(lvdsClkOut2), .slotStart(slotStart2),
      .running(running2), .underflow(underflow2), .underflowClear(underflowClear2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Present a word and wait (bounded) until it is accepted; queue its expected slot.
   task automatic send_word(input logic [27:0] d);
      int n = 0;
      pixelData = d;
      pixelValid = 1'b1;
      #1;
      while (!pixelReady && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!pixelReady) begin
         vectors++; miscompares++;
         $display("FAIL send_timeout: pixelReady 0, want 1");
      end else begin
         @(posedge clk);
         sb_q.push_back(d);
         #1;
      end
      pixelValid = 1'b0;
   endtask

   task automatic send_word2(input logic [4:0] d);
      int n = 0;
      pixelData2 = d;
      pixelValid2 = 1'b1;
      #1;
      while (!pixelReady2 && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (!pixelReady2) begin
         vectors++; miscompares++;
         $display("FAIL send2_timeout: pixelReady 0, want 1");
      end else begin
         @(posedge clk);
         sb2_q.push_back(d);
         #1;
      end
      pixelValid2 = 1'b0;
   endtask

   // Drop enable once the holding register has been consumed, so the next boundary stops.
   task automatic stop_when_empty(input bit second);
      int n = 0;
      #1;
      while (!(second ? pixelReady2 : pixelReady) && n < 100) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 100) begin
         vectors++; miscompares++;
         $display("FAIL stop_timeout: pixelReady 0, want 1");
      end
      if (second) enable2 = 1'b0;
      else        enable = 1'b0;
   endtask

   task automatic drain(input bit second);
      int n = 0;
      while (((second ? sb2_q.size() : sb_q.size()) != 0 || (second ? mon2_busy : mon_busy)) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         vectors++; miscompares++;
         $display("FAIL drain_timeout: %0d slots outstanding, want 0", second ? sb2_q.size() : sb_q.size());
      end
      tick_n(2);
   endtask

   // Rebuild each 4x7 slot from the serial outputs and compare with the queue.
   initial begin : mon1
      logic [27:0] got;
      logic [6:0]  clkw;
      logic [27:0] exp_w;
      bit          aborted;
      forever begin
         @(negedge clk);
         if (resetN && slotStart) begin
            mon_busy = 1'b1;
            aborted = 1'b0;
            for (int k = 0; k < 7; k++) begin
               if (k > 0) begin
                  @(negedge clk);
                  if (!resetN) begin
                     aborted = 1'b1;
                     break;
                  end
                  check("slot_start_mid", 32'(slotStart), 32'd0);
               end
               for (int l = 0; l < 4; l++) got[l*7 + 6 - k] = lvdsData[l];
               clkw[6 - k] = lvdsClkOut;
            end
            if (!aborted) begin
               if (sb_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL extra_slot: got data 0x%0h, want no slot", got);
               end else begin
                  exp_w = sb_q.pop_front();
                  check("slot_data", 32'(got), 32'(exp_w));
                  check("slot_clk", 32'(clkw), 32'h63);
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   // Same for the 1x5 instance; queued back-to-back slots must follow with no gap.
   initial begin : mon2
      logic [4:0] got;
      logic [4:0] clkw;
      logic [4:0] exp_w;
      bit         expect_next;
      expect_next = 1'b0;
      forever begin
         @(negedge clk);
         if (expect_next) check("slot2_period", 32'(slotStart2), 32'd1);
         expect_next = 1'b0;
         if (resetN2 && slotStart2) begin
            mon2_busy = 1'b1;
            for (int k = 0; k < 5; k++) begin
               if (k > 0) begin
                  @(negedge clk);
                  check("slot2_start_mid", 32'(slotStart2), 32'd0);
               end
               got[4 - k] = lvdsData2[0];
               clkw[4 - k] = lvdsClkOut2;
            end
            if (sb2_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL extra_slot2: got data 0x%0h, want no slot", got);
            end else begin
               exp_w = sb2_q.pop_front();
               check("slot2_data", 32'(got), 32'(exp_w));
               check("slot2_clk", 32'(clkw), 32'h1C);
               expect_next = (sb2_q.size() != 0);
            end
            mon2_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: run still active, want completion");
      $fatal(1);
   end

   initial begin : stim
      logic [27:0] w;
      resetN = 1'b0; enable = 1'b0; pixelValid = 1'b0; pixelData = 28'h0; underflowClear = 1'b0;
      resetN2 = 1'b0; enable2 = 1'b0; pixelValid2 = 1'b0; pixelData2 = 5'h0; underflowClear2 = 1'b0;
      tick_n(3);
      check("rst_data", 32'(lvdsData), 32'd0);
      check("rst_clk", 32'(lvdsClkOut), 32'd0);
      check("rst_slot", 32'(slotStart), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_ready", 32'(pixelReady), 32'd0);
      check("rst2_data", 32'(lvdsData2), 32'd0);
      resetN = 1'b1; resetN2 = 1'b1;
      tick();

      // Steady word, then ten distinct back-to-back words; first slot after start is idle.
      enable = 1'b1;
      sb_q.push_back(28'h0);
      for (int i = 0; i < 3; i++) send_word(28'h0ABCDEF);
      for (int i = 0; i < 10; i++) begin
         w = 28'h9C5A3E1 + 28'h0123457 * 28'(i);
         send_word(w);
      end
      check("b2b_underflow", 32'(underflow), 32'd0);
      stop_when_empty(1'b0);
      drain(1'b0);
      check("b2b_stopped", 32'(running), 32'd0);
      check("b2b_underflow_end", 32'(underflow), 32'd0);
      check("b2b_clk_idle", 32'(lvdsClkOut), 32'd0);

      // Underflow: idle start slot is silent, later empty slots set the flag.
      enable = 1'b1;
      sb_q.push_back(28'h0);
      tick();
      send_word(28'h7654321);
      tick_n(6);
      check("uf_first_slots", 32'(underflow), 32'd0);
      sb_q.push_back(28'h0);
      tick_n(7);
      check("uf_set", 32'(underflow), 32'd1);
      underflowClear = 1'b1; tick(); underflowClear = 1'b0;
      check("uf_clear", 32'(underflow), 32'd0);
      sb_q.push_back(28'h0);
      tick_n(5);
      underflowClear = 1'b1; tick(); underflowClear = 1'b0;
      check("uf_set_wins", 32'(underflow), 32'd1);
      enable = 1'b0;
      tick_n(7);
      check("uf_stopped", 32'(running), 32'd0);
      drain(1'b0);
      underflowClear = 1'b1; tick(); underflowClear = 1'b0;
      check("uf_cleared_idle", 32'(underflow), 32'd0);

      // Drop enable mid-slot: slot completes, held word goes first after restart.
      enable = 1'b1;
      sb_q.push_back(28'h0);
      send_word(28'hA5A5A5A);
      send_word(28'h5B6C7D8);
      tick_n(2);
      enable = 1'b0;
      tick_n(4);
      check("stop_running", 32'(running), 32'd0);
      check("stop_slot", 32'(slotStart), 32'd0);
      check("stop_data", 32'(lvdsData), 32'd0);
      check("stop_clk", 32'(lvdsClkOut), 32'd0);
      tick_n(3);
      check("stop_ready", 32'(pixelReady), 32'd0);
      check("stop_data_later", 32'(lvdsData), 32'd0);
      enable = 1'b1;
      tick();
      check("restart_slot", 32'(slotStart), 32'd1);
      check("restart_running", 32'(running), 32'd1);
      stop_when_empty(1'b0);
      drain(1'b0);
      check("restart_stopped", 32'(running), 32'd0);

      // Reset mid-slot with a held word: outputs clear, held word discarded.
      enable = 1'b1;
      sb_q.push_back(28'h0);
      send_word(28'h0C0FFEE);
      tick_n(4);
      resetN = 1'b0;
      sb_q.delete();
      tick();
      check("midrst_data", 32'(lvdsData), 32'd0);
      check("midrst_clk", 32'(lvdsClkOut), 32'd0);
      check("midrst_slot", 32'(slotStart), 32'd0);
      check("midrst_running", 32'(running), 32'd0);
      check("midrst_underflow", 32'(underflow), 32'd0);
      resetN = 1'b1;
      sb_q.push_back(28'h0);
      tick();
      check("midrst_restart_slot", 32'(slotStart), 32'd1);
      enable = 1'b0;
      drain(1'b0);
      check("midrst_underflow_end", 32'(underflow), 32'd0);
      check("midrst_stopped", 32'(running), 32'd0);

      // RATIO=5 single-lane instance: period 5, MSB first, clock 11100.
      enable2 = 1'b1;
      sb2_q.push_back(5'h00);
      send_word2(5'h13);
      send_word2(5'h0A);
      send_word2(5'h1F);
      stop_when_empty(1'b1);
      drain(1'b1);
      check("r5_stopped", 32'(running2), 32'd0);
      check("r5_data_idle", 32'(lvdsData2), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lvds_tx_serializer.md
Name: lvds_tx_serializer

Overview:
- Parametrised N-lane FPD-Link style LVDS transmitter core. Runs entirely in the PLL bit-clock domain (e.g. 336 MHz = 7 x 48 MHz pixel clock).
- Accepts one parallel pixel word per slot through a valid/ready handshake and serialises it MSB-first on LANES data lanes.
- Generates the matching forwarded clock-lane pattern and reports underflow.
- Sits between the pixel/timing generator and the LVDS output pads, downstream of the pixel-clock PLL.

Parameters:
- LANES, 4, number of LVDS data lanes (1..8).
- RATIO, 7, serialisation ratio: bits per lane per slot (2..16).
- CLK_PATTERN, 7'b1100011, clock-lane word, RATIO bits, sent MSB first every slot.
- IDLE_WORD, 0, LANES*RATIO-bit word sent in place of missing data.

Ports:
- lvdsBitClock  in  1  bit clock; all logic on its rising edge.
- resetN  in  1  synchronous active-low reset.
- enable  in  1  serialiser run request.
- pixelData  in  LANES*RATIO  parallel word; lane l uses bits [l*RATIO +: RATIO].
- pixelValid  in  1  pixelData valid.
- pixelReady  out  1  holding register can accept a word.
- lvdsData  out  LANES  serial data, one bit per lane.
- lvdsClkOut  out  1  forwarded clock-lane bit.
- slotStart  out  1  high in the cycle the MSB of a slot is on the outputs.
- running  out  1  serialiser is actively emitting slots.
- underflow  out  1  sticky: a slot boundary found no word.
- underflowClear  in  1  clears underflow.

Behaviour:
- Reset (resetN=0 at an edge): cnt=0, running=0, holdFull=0, all shift regs=0, and lvdsData, lvdsClkOut, slotStart, underflow, pixelReady all 0.
- Handshake:
  - pixelReady = running_or_starting && !holdFull, where running_or_starting = enable || running.
  - Transfer when pixelValid && pixelReady at an edge; holdData <= pixelData, holdFull <= 1.
  - Holding a word is a 1-deep buffer. While full, pixelReady=0 and pixelValid is ignored.
- Slot counter cnt counts 0..RATIO-1 while running and wraps to 0. Load cycle = cnt==RATIO-1.
- Start: when running=0 and enable=1, the next edge performs a load (running<=1, cnt<=0). The first slot therefore begins one cycle after enable rises.
- Load edge (start edge, or running && cnt==RATIO-1):
  - If holdFull: each lane shreg <= holdData lane slice; holdFull <= 0, unless a new transfer occurs on that same edge, which refills it (holdFull stays 1).
  - Else: shreg <= IDLE_WORD slices and underflow <= 1. Start edges never set underflow.
  - clkShreg <= CLK_PATTERN.
- Non-load edges while running: each shreg and clkShreg shift left by 1 with zero fill.
- Outputs: lvdsData[l] = shreg[l][RATIO-1] and lvdsClkOut = clkShreg[RATIO-1]. Both come straight from flops (registered).
- slotStart is registered and is 1 exactly in the cycle following a load edge.
- Latency: a word accepted at edge t is loaded at the next load edge L ≥ t+1. Its MSB appears in cycle L+1 and its LSB in cycle L+RATIO.
- Stop: enable is sampled only at load edges. If enable=0 at a load edge:
  - running <= 0, shregs <= 0, cnt <= 0.
  - The current slot always completes; there are no partial slots.
  - The holding register is retained and sent first on restart.
- While stopped, outputs stay 0.
- underflowClear=1 clears underflow at the edge, but a simultaneous underflow set wins (flag stays 1).
- Reset mid-slot aborts immediately. Outputs are 0 in the cycle after reset and the held word is discarded.
- Width rules: cnt is clog2(RATIO) bits. RATIO not a power of two must still wrap at RATIO-1, never at 2^n-1.

Test Plan:
- LANES=4, RATIO=7, reset then enable=1, valid held with pixelData=28'h0ABCDEF -> lvdsClkOut repeats 1100011 every 7 cycles with no gaps. Lane0 shows 1101111 (7'h6F) MSB first aligned to slotStart. underflow stays 0.
- Continuous back-to-back words W0..W9 with pixelValid always 1 -> pixelReady pulses once per slot. All 10 words appear in order with no idle slot between them.
- Enable with no valid for the first slot, then a single word -> slot 1 sends IDLE_WORD without setting underflow. Any later empty slot sets underflow=1. underflowClear pulsed on a non-load cycle returns it to 0. Pulsed on a load cycle that underflows, it stays 1.
- Drop enable at cnt=3 -> the current slot finishes all 7 bits, then outputs go 0 and running=0. A word held during the stop is the first word sent after re-enable, one cycle after enable rises.
- Assert resetN=0 at cnt=4 with holdFull=1 -> next cycle all outputs are 0. After release with enable=1, the first slot is IDLE_WORD, confirming the held word was discarded.
- RATIO=5, LANES=1, CLK_PATTERN=5'b11100 -> cnt wraps every 5 cycles, slotStart period is 5, and data is correct MSB-first.
